instr_fetch_unit: RTL

Parametrised instruction fetch stage that replaces the externally driven `instruction` input of the `cpu` top level. It owns the program counter and a loadable instruction memory, and holds a small prefetch FIFO. It hands instructions to decode over a valid/ready handshake, takes branch redirects from execute, and stops fetching after a HALT opcode.

---
 rtl/instr_fetch_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage: owns the fetch PC, a loadable instruction memory
// with a 1-cycle synchronous read, and a small first-word-fall-through
// prefetch FIFO feeding decode over a valid/ready handshake. Execute can
// redirect fetch (flush + refetch). Fetch stops after a HALT opcode returns.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-low reset
//   load_en         write load_data into memory at load_addr
//   load_addr       memory write address
//   load_data       memory write data
//   redirect_valid  taken branch/jump: flush FIFO, drop in-flight read
//   redirect_pc     new fetch address
//   instr_ready     decode accepts the FIFO head
//   instr_valid     FIFO head valid
//   instr_data      FIFO head instruction (0 when empty)
//   instr_pc        word address of instr_data (0 when empty)
//   fetch_halted    HALT returned; no further reads issue
//   fifo_count      occupied FIFO entries
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int          INSTR_W    = 32,
    parameter int          DEPTH      = 256,
    parameter int          FIFO_DEPTH = 4,
    parameter int          RESET_PC   = 0,
    parameter logic [3:0]  HALT_OP    = 4'hF,
    localparam int         AW         = $clog2(DEPTH),
    localparam int         CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [AW-1:0]      load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               redirect_valid,
    input  logic [AW-1:0]      redirect_pc,
    input  logic               instr_ready,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [AW-1:0]      instr_pc,
    output logic               fetch_halted,
    output logic [CW-1:0]      fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [INSTR_W-1:0] rd_data_q;

    logic [AW-1:0]      pc_q;
    logic               inflight_q;
    logic [AW-1:0]      inflight_pc_q;

    logic [INSTR_W-1:0] fifo_data [FIFO_DEPTH];
    logic [AW-1:0]      fifo_pc   [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic               halted_q;

    logic               issue;
    logic               push;
    logic               pop;
    logic               halt_seen;
    logic [CW:0]        occupancy;

    always_comb begin
        occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        push      = inflight_q && !redirect_valid;
        halt_seen = push && (rd_data_q[INSTR_W-1 -: 4] == HALT_OP);
        pop       = (count_q != '0) && instr_ready;
        // A HALT returning this cycle already blocks the next read, so the
        // word after HALT is never fetched. Pops are not credited here.
        issue     = (occupancy < (CW+1)'(FIFO_DEPTH)) && !halted_q
                    && !halt_seen && !redirect_valid;
    end

    // Memory and read register carry no reset; non-blocking semantics give
    // old data on a same-address read/write.
    always_ff @(posedge clk) begin
        if (load_en)
            mem[load_addr] <= load_data;
        if (issue)
            rd_data_q <= mem[pc_q];
    end

    // FIFO storage is only meaningful below count_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= rd_data_q;
            fifo_pc[wr_ptr_q]   <= inflight_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= AW'(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            halted_q      <= 1'b0;
        end else if (redirect_valid) begin
            pc_q       <= redirect_pc;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            halted_q   <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + AW'(1);
            end
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)
                count_q <= count_q + CW'(1);
            else if (pop && !push)
                count_q <= count_q - CW'(1);
            if (halt_seen)
                halted_q <= 1'b1;
        end
    end

    assign instr_valid  = (count_q != '0);
    assign instr_data   = instr_valid ? fifo_data[rd_ptr_q] : '0;
    assign instr_pc     = instr_valid ? fifo_pc[rd_ptr_q]   : '0;
    assign fetch_halted = halted_q;
    assign fifo_count   = count_q;

endmodule
